// File: rtl/pic10_pkg.sv
// Shared constants and types for the PIC10 fetch/sequencing slice.
// Optional stack checking is enabled by defining PIC10_STACK_CHECK_EN.
`timescale 1ns/1ps

package pic10_pkg;

  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned STACK_DEPTH = 2;

  localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 8'hFF;
  localparam logic [11:0]         NOP_WORD     = 12'h000;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_t;

endpackage

// File: rtl/pic10_stack.sv
// Two-level hardware call stack; pop has priority over push.
// With PIC10_STACK_CHECK_EN defined, tracks occupancy and flags overflow/underflow.
`timescale 1ns/1ps

module pic10_stack
  import pic10_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                stack_err
);

  logic [PC_WIDTH-1:0] level0;
  logic [PC_WIDTH-1:0] level1;

  // Pop leaves level1 in place, so an empty-stack return yields the stale entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      level0 <= '0;
      level1 <= '0;
    end else if (pop) begin
      level0 <= level1;
    end else if (push) begin
      level1 <= level0;
      level0 <= push_data;
    end
  end

  assign top = level0;

`ifdef PIC10_STACK_CHECK_EN
  logic [1:0] depth;
  logic       err;

  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= '0;
      err   <= 1'b0;
    end else if (pop) begin
      if (depth == '0) err <= 1'b1;
      else             depth <= depth - 2'd1;
    end else if (push) begin
      if (depth == 2'(STACK_DEPTH)) err <= 1'b1;
      else                          depth <= depth + 2'd1;
    end
  end

  assign stack_err = err;
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: rtl/pic10_fetch.sv
// PIC10 fetch stage: PC, Q1..Q4 phase sequencer, branch/call/return priority, IR load control.
// Define PIC10_STACK_CHECK_EN to enable stack overflow/underflow detection.
`timescale 1ns/1ps

module pic10_fetch
  import pic10_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                goto_en,
  input  logic                call_en,
  input  logic                retlw_en,
  input  logic                skip_en,
  input  logic [PC_WIDTH-1:0] jump_addr,
  output logic [PC_WIDTH-1:0] prog_addr,
  output logic [1:0]          q_phase,
  output logic                load_ir_reg,
  output logic                ir_nop_sel,
  output logic                stack_err
);

  q_phase_t            phase;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] stack_top;
  logic                in_q4;
  logic                commit;
  logic                push;
  logic                pop;

  assign in_q4  = (phase == Q4);
  assign commit = in_q4 && !hold;

  // Priority retlw > call > goto > skip > sequential.
  always_comb begin
    pc_next    = pc + PC_WIDTH'(1);
    ir_nop_sel = 1'b0;
    if (in_q4) begin
      if (retlw_en) begin
        pc_next    = stack_top;
        ir_nop_sel = 1'b1;
      end else if (call_en || goto_en) begin
        pc_next    = jump_addr;
        ir_nop_sel = 1'b1;
      end else if (skip_en) begin
        ir_nop_sel = 1'b1;
      end
    end
  end

  assign pop  = commit && retlw_en;
  assign push = commit && call_en && !retlw_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= Q1;
      pc    <= RESET_VECTOR;
    end else if (!hold) begin
      phase <= q_phase_t'(phase + 2'd1);
      if (in_q4) pc <= pc_next;
    end
  end

  pic10_stack u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .top       (stack_top),
    .stack_err (stack_err)
  );

  assign prog_addr   = pc;
  assign q_phase     = phase;
  assign load_ir_reg = commit;

endmodule

// File: tb/tb_pic10_fetch.sv
// Self-checking bench for pic10_fetch: directed sequence then random control traffic,
// compared every clock against a behavioural model of the instruction-cycle rules.
`timescale 1ns/1ps

module tb_pic10_fetch;

  logic       clk = 1'b0;
  logic       reset, hold, goto_en, call_en, retlw_en, skip_en;
  logic [7:0] jump_addr;
  logic [7:0] prog_addr;
  logic [1:0] q_phase;
  logic       load_ir_reg, ir_nop_sel, stack_err;

  int passes = 0;
  int total  = 0;

  // Behavioural model state
  int m_phase;
  int m_pc;
  int m_stk[2];
  int m_depth;
  bit m_err;

  pic10_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .goto_en     (goto_en),
    .call_en     (call_en),
    .retlw_en    (retlw_en),
    .skip_en     (skip_en),
    .jump_addr   (jump_addr),
    .prog_addr   (prog_addr),
    .q_phase     (q_phase),
    .load_ir_reg (load_ir_reg),
    .ir_nop_sel  (ir_nop_sel),
    .stack_err   (stack_err)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit exp_err();
`ifdef PIC10_STACK_CHECK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_phase = 0; m_pc = 'hFF; m_stk[0] = 0; m_stk[1] = 0; m_depth = 0; m_err = 0;
    end else if (!hold) begin
      if (m_phase == 3) begin
        if (retlw_en) begin
          if (m_depth == 0) m_err = 1; else m_depth--;
          m_pc = m_stk[0];
          m_stk[0] = m_stk[1];
        end else if (call_en) begin
          if (m_depth == 2) m_err = 1; else m_depth++;
          m_stk[1] = m_stk[0];
          m_stk[0] = m_pc;
          m_pc = jump_addr;
        end else if (goto_en) begin
          m_pc = jump_addr;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
      m_phase = (m_phase + 1) % 4;
    end
  endtask

  task automatic check_outputs();
    bit any_ctl;
    any_ctl = goto_en | call_en | retlw_en | skip_en;
    chk("prog_addr",   prog_addr,   m_pc);
    chk("q_phase",     q_phase,     m_phase);
    chk("load_ir_reg", load_ir_reg, (m_phase == 3) && !hold);
    chk("ir_nop_sel",  ir_nop_sel,  (m_phase == 3) && any_ctl);
    chk("stack_err",   stack_err,   exp_err());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic clear_ctl();
    goto_en = 0; call_en = 0; retlw_en = 0; skip_en = 0; jump_addr = '0;
  endtask

  task automatic to_q4();
    for (int i = 0; i < 8 && m_phase != 3; i++) step();
  endtask

  // Present one control in Q4, check the comb decode, then end the instruction cycle.
  task automatic exec(input bit g, input bit c, input bit r, input bit s, input logic [7:0] a);
    to_q4();
    goto_en = g; call_en = c; retlw_en = r; skip_en = s; jump_addr = a;
    #0.2;
    check_outputs();
    chk("nop_sel_q4", ir_nop_sel, 1'b1);
    step();
    clear_ctl();
  endtask

  initial begin
    reset = 1; hold = 0;
    clear_ctl();
    m_phase = 0; m_pc = 'hFF; m_stk[0] = 0; m_stk[1] = 0; m_depth = 0; m_err = 0;

    // Reset held 10 ns
    cyc(5);
    chk("rst_prog_addr", prog_addr, 8'hFF);
    chk("rst_q_phase",   q_phase,   2'd0);
    chk("rst_load_ir",   load_ir_reg, 1'b0);
    reset = 0;

    // First Q4 after release
    cyc(3);
    chk("first_q4_load", load_ir_reg, 1'b1);
    chk("first_q4_nop",  ir_nop_sel,  1'b0);
    step();
    chk("first_pc", prog_addr, 8'h00);

    // Sequential run
    cyc(16);
    chk("seq_pc4", prog_addr, 8'h04);
    cyc(4);
    chk("seq_pc5", prog_addr, 8'h05);

    // GOTO 0x40 at PC=0x05
    exec(1, 0, 0, 0, 8'h40);
    chk("goto_pc", prog_addr, 8'h40);
    cyc(4);
    chk("goto_pc_next", prog_addr, 8'h41);

    // CALL 0x20 from 0x10, CALL 0x30 from 0x20, RETLW twice
    exec(1, 0, 0, 0, 8'h10);
    cyc(4);
    exec(0, 1, 0, 0, 8'h20);
    chk("call1_pc", prog_addr, 8'h20);
    cyc(4);
    exec(0, 1, 0, 0, 8'h30);
    chk("call2_pc", prog_addr, 8'h30);
    cyc(4);
    exec(0, 0, 1, 0, 8'h00);
    chk("ret1_pc", prog_addr, 8'h21);
    cyc(4);
    exec(0, 0, 1, 0, 8'h00);
    chk("ret2_pc", prog_addr, 8'h11);
    chk("stack_ok", stack_err, 1'b0);

    // Three nested CALLs then RETLW x3: return 0x11 is lost
    exec(0, 1, 0, 0, 8'h50); cyc(4);
    exec(0, 1, 0, 0, 8'h60); cyc(4);
    exec(0, 1, 0, 0, 8'h70);
`ifdef PIC10_STACK_CHECK_EN
    chk("overflow_err", stack_err, 1'b1);
`else
    chk("overflow_err", stack_err, 1'b0);
`endif
    cyc(4);
    exec(0, 0, 1, 0, 8'h00);
    chk("nret1_pc", prog_addr, 8'h61);
    cyc(4);
    exec(0, 0, 1, 0, 8'h00);
    chk("nret2_pc", prog_addr, 8'h51);
    cyc(4);
    exec(0, 0, 1, 0, 8'h00);
    chk("nret3_pc", prog_addr, 8'h51);

    // Wrap 0xFF -> 0x00
    exec(1, 0, 0, 0, 8'hFF);
    chk("wrap_ff", prog_addr, 8'hFF);
    cyc(4);
    chk("wrap_00", prog_addr, 8'h00);

    // Skip
    exec(0, 0, 0, 1, 8'h00);
    chk("skip_pc", prog_addr, 8'h01);

    // Hold for 6 clocks while in Q4
    to_q4();
    hold = 1;
    #0.2;
    chk("hold_load", load_ir_reg, 1'b0);
    cyc(6);
    chk("hold_phase", q_phase,   2'd3);
    chk("hold_pc",    prog_addr, 8'h01);
    hold = 0;
    step();
    chk("after_hold_pc", prog_addr, 8'h02);

    // Reset asserted in Q2
    for (int i = 0; i < 8 && m_phase != 1; i++) step();
    reset = 1;
    step();
    chk("q2rst_phase", q_phase,   2'd0);
    chk("q2rst_pc",    prog_addr, 8'hFF);
    reset = 0;

    // Random control traffic
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      hold      = ($urandom_range(0, 7) == 0);
      goto_en   = ($urandom_range(0, 5) == 0);
      call_en   = ($urandom_range(0, 5) == 0);
      retlw_en  = ($urandom_range(0, 5) == 0);
      skip_en   = ($urandom_range(0, 5) == 0);
      jump_addr = 8'($urandom);
      step();
    end
    reset = 0; hold = 0;
    clear_ctl();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
